// File: rtl/mode_stream_max.sv
// -----------------------------------------------------------------------------
// mode_stream_max
//
// Collects a frame of DEPTH unsigned WIDTH-bit samples into a per-value
// histogram, then scans the histogram once and reports the most frequent
// value (largest value wins a tie) together with its occurrence count.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sample valid
//   in_ready   block can accept a sample (high only while accumulating)
//   in_data    sample value, unsigned WIDTH bits
//   out_valid  result valid (held until out_ready)
//   out_ready  downstream accepts the result
//   out_mode   most frequent value of the frame, largest among ties
//   out_count  occurrences of out_mode in the frame (1..DEPTH)
//   busy       high while scanning or presenting a result
// -----------------------------------------------------------------------------
module mode_stream_max #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mode,
    output logic [CW-1:0]    out_count,
    output logic             busy
);

    localparam int NBINS = 1 << WIDTH;

    localparam logic [CW-1:0]    LAST_SAMPLE = CW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] LAST_IDX    = WIDTH'(NBINS - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] idx_q;
    logic [WIDTH-1:0] idx_d;
    logic [WIDTH-1:0] best_val_q;
    logic [WIDTH-1:0] best_val_d;
    logic [CW-1:0]    best_cnt_q;
    logic [CW-1:0]    best_cnt_d;
    logic [CW-1:0]    bins_q [NBINS];
    logic [CW-1:0]    bins_d [NBINS];

    // State, counters, scan result and histogram registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            cnt_q      <= '0;
            idx_q      <= '0;
            best_val_q <= '0;
            best_cnt_q <= '0;
            for (int i = 0; i < NBINS; i++) begin
                bins_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            best_val_q <= best_val_d;
            best_cnt_q <= best_cnt_d;
            for (int i = 0; i < NBINS; i++) begin
                bins_q[i] <= bins_d[i];
            end
        end
    end

    // Next-state logic: histogram accumulation, histogram scan, result hold.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        best_val_d = best_val_q;
        best_cnt_d = best_cnt_q;
        for (int i = 0; i < NBINS; i++) begin
            bins_d[i] = bins_q[i];
        end

        case (state_q)
            ST_ACCUM: begin
                // in_ready is high for the whole of this state, so in_valid
                // alone qualifies a transfer.
                if (in_valid) begin
                    // A bin never exceeds DEPTH within a frame, so CW bits
                    // cannot overflow here.
                    bins_d[in_data] = bins_q[in_data] + CW'(1);
                    if (cnt_q == LAST_SAMPLE) begin
                        cnt_d      = '0;
                        idx_d      = '0;
                        best_val_d = '0;
                        best_cnt_d = '0;
                        state_d    = ST_SCAN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_SCAN: begin
                // Clearing each bin as it is read leaves an empty histogram
                // for the next frame without a separate clear pass.
                bins_d[idx_q] = '0;
                // >= lets a later (larger) index take over an equal count.
                if (bins_q[idx_q] >= best_cnt_q) begin
                    best_val_d = idx_q;
                    best_cnt_d = bins_q[idx_q];
                end else begin
                    best_val_d = best_val_q;
                    best_cnt_d = best_cnt_q;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    idx_d = idx_q + WIDTH'(1);
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_OUT;
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Outputs are register values or pure decodes of the state register.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q == ST_SCAN) || (state_q == ST_OUT);
    assign out_mode  = best_val_q;
    assign out_count = best_cnt_q;

endmodule
